// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM encoding, handshake levels and sign helper for the divider
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [5:0] DIV_ITERATIONS = 6'd32;

    function automatic logic [31:0] cond_negate(input logic neg, input logic [31:0] value);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration on the 65-bit working register
module div_step (
    input  logic [64:0] work,
    input  logic [31:0] divisor,
    output logic [64:0] work_next
);

    logic [32:0] trial;

    always_comb begin
        trial = work[63:31] - {1'b0, divisor};
        if (trial[32]) begin
            work_next = {work[63:0], 1'b0};
        end else begin
            // work[64] is always zero here; carrying it keeps the register width uniform
            work_next = {work[64], trial[31:0], work[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/div.sv
// rtl/div.sv - multi-cycle 32-bit DIV/DIVU unit; DIV_SIGNED_EN enables signed operation
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state, state_next;
    logic [5:0]  cnt, cnt_next;
    logic [64:0] work, work_next, work_step;
    logic [31:0] divisor, divisor_next;
    logic        neg_quo, neg_quo_next;
    logic        neg_rem, neg_rem_next;
    logic [63:0] result_next;
    logic        ready_next;
    logic        sign_mode;

`ifdef DIV_SIGNED_EN
    assign sign_mode = signed_div_i;
`else
    assign sign_mode = signed_div_i & 1'b0;
`endif

    div_step u_step (
        .work      (work),
        .divisor   (divisor),
        .work_next (work_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            work     <= work_next;
            divisor  <= divisor_next;
            neg_quo  <= neg_quo_next;
            neg_rem  <= neg_rem_next;
            result_o <= result_next;
            ready_o  <= ready_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        work_next    = work;
        divisor_next = divisor;
        neg_quo_next = neg_quo;
        neg_rem_next = neg_rem;
        result_next  = result_o;
        ready_next   = ready_o;

        case (state)
            DIV_FREE: begin
                result_next = '0;
                ready_next  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_next = DIV_BY_ZERO;
                    end else begin
                        work_next    = {33'd0, cond_negate(sign_mode & opdata1_i[31], opdata1_i)};
                        divisor_next = cond_negate(sign_mode & opdata2_i[31], opdata2_i);
                        neg_quo_next = sign_mode & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_next = sign_mode & opdata1_i[31];
                        cnt_next     = '0;
                        state_next   = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_next = DIV_FREE;
                end else begin
                    state_next  = DIV_END;
                    result_next = '0;
                    ready_next  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end else if (cnt == DIV_ITERATIONS) begin
                    result_next = {cond_negate(neg_rem, work[63:32]), cond_negate(neg_quo, work[31:0])};
                    ready_next  = DIV_RESULT_READY;
                    state_next  = DIV_END;
                end else begin
                    work_next = work_step;
                    cnt_next  = cnt + 6'd1;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_next = DIV_FREE;
        endcase
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed vector bench for the divider; expectations follow DIV_SIGNED_EN
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_vec = 0;
    int n_bad = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues a request, measures latency from the accepting edge, checks result and hold.
    task automatic run_req(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int cycles;
        @(negedge clk);
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        opdata1 = 32'h1234_5678;
        opdata2 = 32'h0000_0001;
        signed_div = ~sgn;
        cycles = 0;
        while (ready !== 1'b1 && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({name, " latency"}, 64'(cycles), 64'(lat));
        check({name, " result"}, result, exp);
        repeat (2) @(posedge clk);
        #1;
        check({name, " hold"}, {result[62:0], ready}, {exp[62:0], 1'b1});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({name, " release"}, {ready, result}, 65'd0);
    endtask

    task automatic expect_idle(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33};
        vecs[1] = '{1'b0, 32'd5, 32'd0, 64'd0, 1};
        vecs[2] = '{1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 33};
        vecs[3] = '{1'b0, 32'h8000_0000, 32'd1, {32'd0, 32'h8000_0000}, 33};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1}, 33};
        vecs[5] = '{1'b1, 32'd5, 32'd0, 64'd0, 1};
`ifdef DIV_SIGNED_EN
        vecs[6] = '{1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
        vecs[7] = '{1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33};
        vecs[8] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}, 33};
        vecs[9] = '{1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33};
`else
        vecs[6] = '{1'b1, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33};
        vecs[7] = '{1'b1, 32'd7, 32'hFFFF_FFFE, {32'd7, 32'd0}, 33};
        vecs[8] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFF8, 32'd0}, 33};
        vecs[9] = '{1'b1, 32'hFFFF_FF9C, 32'd7, {32'd2, 32'h2492_4916}, 33};
`endif

        rst        = 1'b1;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {ready, result}, 65'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Annul after ten iterations: no result may ever appear.
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'hFFFF_FFFF;
        opdata2    = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        expect_idle("annul no ready", 40);
        run_req("after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Overflow case with a longer hold.
        @(negedge clk);
        signed_div = 1'b1;
        opdata1    = 32'h8000_0000;
        opdata2    = 32'hFFFF_FFFF;
        start      = 1'b1;
        begin
            int cycles;
            cycles = 0;
            @(posedge clk);
            #1;
            while (ready !== 1'b1 && cycles < 60) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            check("ovf latency", 64'(cycles), 64'd33);
`ifdef DIV_SIGNED_EN
            check("ovf result", result, {32'd0, 32'h8000_0000});
`else
            check("ovf result", result, {32'h8000_0000, 32'd0});
`endif
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                check($sformatf("ovf hold%0d", i), 64'(ready), 64'd1);
            end
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #1;
            check("ovf release", {ready, result}, 65'd0);
        end

        // Asynchronous reset during iteration 20.
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst mid-on", {ready, result}, 65'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect_idle("rst idle", 40);
        run_req("after rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        opdata1 = 32'd50;
        opdata2 = 32'd6;
        start   = 1'b1;
        repeat (36) @(posedge clk);
        #1;
        check("held before rst", {ready, result}, {1'b1, 32'd2, 32'd8});
        #2;
        rst = 1'b1;
        #1;
        check("rst in end", {ready, result}, 65'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
